exe_stage_pipe: RTL and testbench

//  Parametrised, registered execute stage for the 3-stage RISC core: operand mux, ALU, branch-target add, SW input / LED output ops.

---
 rtl/exe_pkg.sv | 27 ++
 rtl/exe_stage_pipe_seq_mul.sv | 55 +++++
 rtl/exe_stage_pipe.sv | 170 +++++++++++++++++
 tb/tb_exe_stage_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: command encoding and stage FSM states.
package exe_pkg;

  localparam int EXE_CMD_LEN = 4;

  typedef enum logic [EXE_CMD_LEN-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_AND = 4'd3,
    CMD_OR  = 4'd4,
    CMD_XOR = 4'd5,
    CMD_SHL = 4'd6,
    CMD_SHR = 4'd7,
    CMD_MOV = 4'd8,
    CMD_MUL = 4'd9,
    CMD_IN  = 4'd10,
    CMD_OUT = 4'd11
  } exe_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL_BUSY,
    DONE
  } exe_state_t;

endpackage

// File: rtl/exe_stage_pipe_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first,
// keeps only the low WIDTH bits of the product.
module seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [CW-1:0]    count_reg;
  logic             busy_reg;

  // done marks the cycle in which the final partial product is added
  assign done    = busy_reg && (count_reg == CW'(WIDTH - 1));
  assign busy    = busy_reg;
  assign product = acc_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      busy_reg   <= 1'b0;
    end else if (start) begin
      acc_reg    <= '0;
      mcand_reg  <= a;
      mplier_reg <= b;
      count_reg  <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      if (done) begin
        busy_reg  <= 1'b0;
        count_reg <= '0;
      end else begin
        count_reg <= count_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/exe_stage_pipe.sv
// Registered execute stage: ALU, branch-target add, SW/LED ops, optional
// iterative multiplier, single EX/WB output slot with valid/ready and flush.
module exe_stage_pipe
  import exe_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 3,
  parameter int LED_W      = 16,
  parameter int MUL_EN     = 1
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   ImSel,
  input  logic [EXE_CMD_LEN-1:0] EXE_CMD,
  input  logic                   Reg_W_EN_IN,
  input  logic                   BranchTK_IN,
  input  logic [WIDTH-1:0]       RD1,
  input  logic [WIDTH-1:0]       RD2,
  input  logic [WIDTH-1:0]       IMMG,
  input  logic [WIDTH-1:0]       PC,
  input  logic [WIDTH-1:0]       Instruction,
  input  logic [WIDTH-1:0]       SW,
  input  logic                   Flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       Wdata,
  output logic [WIDTH-1:0]       Broffset,
  output logic [REG_ADDR_W-1:0]  Rd,
  output logic                   Reg_W_EN,
  output logic                   BranchTK,
  output logic [LED_W-1:0]       LED
);

  localparam int SH_W = $clog2(WIDTH);

  exe_state_t state_reg, state_next;

  logic                  out_valid_reg;
  logic [WIDTH-1:0]      wdata_reg, broffset_reg;
  logic [REG_ADDR_W-1:0] rd_reg;
  logic                  wen_reg, br_reg;
  logic [WIDTH-1:0]      p_broffset_reg;
  logic [REG_ADDR_W-1:0] p_rd_reg;
  logic                  p_wen_reg, p_br_reg;
  logic [LED_W-1:0]      led_reg;

  logic [WIDTH-1:0] alu_b, alu_y, br_sum, mul_product;
  logic             wen_op, slot_free, accept, pop, is_mul, mul_start;
  logic             mul_busy, mul_done, mul_clr, load_mul;
  logic             unused_bits;

  assign alu_b     = ImSel ? IMMG : RD2;
  assign br_sum    = PC + IMMG;
  assign slot_free = !out_valid_reg || out_ready;
  assign in_ready  = (state_reg == IDLE) && !mul_busy && slot_free && !Flush;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid_reg && out_ready;
  assign is_mul    = (MUL_EN != 0) && (EXE_CMD == CMD_MUL);
  assign mul_start = accept && is_mul;
  assign mul_clr   = Reset || Flush;
  assign load_mul  = (state_reg == DONE) && slot_free && !Flush;
  assign unused_bits = ^Instruction[WIDTH-1:REG_ADDR_W];

  generate
    if (MUL_EN != 0) begin : g_mul
      seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .srst    (mul_clr),
        .start   (mul_start),
        .a       (RD1),
        .b       (alu_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_busy    = 1'b0;
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  always_comb begin
    alu_y  = '0;
    wen_op = Reg_W_EN_IN;
    case (EXE_CMD)
      CMD_ADD: alu_y = RD1 + alu_b;
      CMD_SUB: alu_y = RD1 - alu_b;
      CMD_AND: alu_y = RD1 & alu_b;
      CMD_OR:  alu_y = RD1 | alu_b;
      CMD_XOR: alu_y = RD1 ^ alu_b;
      CMD_SHL: alu_y = RD1 << alu_b[SH_W-1:0];
      CMD_SHR: alu_y = RD1 >> alu_b[SH_W-1:0];
      CMD_MOV: alu_y = alu_b;
      CMD_IN:  alu_y = SW;
      CMD_OUT: alu_y = RD1;
      // only reached here when the multiplier is absent
      CMD_MUL: wen_op = 1'b0;
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (mul_start) state_next = MUL_BUSY;
      MUL_BUSY: if (mul_done)  state_next = DONE;
      DONE:     if (slot_free) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (Flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_reg      <= IDLE;
      out_valid_reg  <= 1'b0;
      wdata_reg      <= '0;
      broffset_reg   <= '0;
      rd_reg         <= '0;
      wen_reg        <= 1'b0;
      br_reg         <= 1'b0;
      p_broffset_reg <= '0;
      p_rd_reg       <= '0;
      p_wen_reg      <= 1'b0;
      p_br_reg       <= 1'b0;
      led_reg        <= '0;
    end else begin
      state_reg <= state_next;
      if (accept && (EXE_CMD == CMD_OUT)) led_reg <= RD1[LED_W-1:0];
      // multiply side-band is parked until the product is ready
      if (mul_start) begin
        p_broffset_reg <= br_sum;
        p_rd_reg       <= Instruction[REG_ADDR_W-1:0];
        p_wen_reg      <= Reg_W_EN_IN;
        p_br_reg       <= BranchTK_IN;
      end
      if (Flush) begin
        out_valid_reg <= 1'b0;
      end else if (load_mul) begin
        out_valid_reg <= 1'b1;
        wdata_reg     <= mul_product;
        broffset_reg  <= p_broffset_reg;
        rd_reg        <= p_rd_reg;
        wen_reg       <= p_wen_reg;
        br_reg        <= p_br_reg;
      end else if (accept && !is_mul) begin
        out_valid_reg <= 1'b1;
        wdata_reg     <= alu_y;
        broffset_reg  <= br_sum;
        rd_reg        <= Instruction[REG_ADDR_W-1:0];
        wen_reg       <= wen_op;
        br_reg        <= BranchTK_IN;
      end else if (pop) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign Wdata     = wdata_reg;
  assign Broffset  = broffset_reg;
  assign Rd        = rd_reg;
  assign Reg_W_EN  = out_valid_reg && wen_reg;
  assign BranchTK  = out_valid_reg && br_reg;
  assign LED       = led_reg;

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Randomized and directed bench for exe_stage_pipe against a transaction-level
// reference model (slot occupancy, multiply countdown, arithmetic results).
module tb_exe_stage_pipe;
  import exe_pkg::*;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        Reset, in_valid, ImSel, Reg_W_EN_IN, BranchTK_IN, Flush, out_ready;
  logic [3:0]  EXE_CMD;
  logic [15:0] RD1, RD2, IMMG, PC, Instruction, SW;
  logic        in_ready, out_valid, Reg_W_EN, BranchTK;
  logic [15:0] Wdata, Broffset, LED;
  logic [2:0]  Rd;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic        m_valid = 1'b0;
  logic [15:0] m_wdata = '0, m_bro = '0, m_led = '0;
  logic [2:0]  m_rd = '0;
  logic        m_wen = 1'b0, m_br = 1'b0;
  int          mul_cnt = 0;
  logic [15:0] q_wdata, q_bro;
  logic [2:0]  q_rd;
  logic        q_wen, q_br;

  exe_stage_pipe #(.WIDTH(16), .REG_ADDR_W(3), .LED_W(16), .MUL_EN(1)) dut (
    .clk(clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .ImSel(ImSel), .EXE_CMD(EXE_CMD), .Reg_W_EN_IN(Reg_W_EN_IN),
    .BranchTK_IN(BranchTK_IN), .RD1(RD1), .RD2(RD2), .IMMG(IMMG), .PC(PC),
    .Instruction(Instruction), .SW(SW), .Flush(Flush), .out_valid(out_valid),
    .out_ready(out_ready), .Wdata(Wdata), .Broffset(Broffset), .Rd(Rd),
    .Reg_W_EN(Reg_W_EN), .BranchTK(BranchTK), .LED(LED)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_res(input int cmd, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] sw);
    int unsigned ia, ib;
    ia = a; ib = b;
    case (cmd)
      CMD_ADD: return 16'((ia + ib) % 65536);
      CMD_SUB: return 16'((ia + 65536 - ib) % 65536);
      CMD_AND: return a & b;
      CMD_OR:  return a | b;
      CMD_XOR: return a ^ b;
      CMD_SHL: return 16'((ia * (1 << (ib % 16))) % 65536);
      CMD_SHR: return 16'(ia / (1 << (ib % 16)));
      CMD_MOV: return b;
      CMD_MUL: return 16'((ia * ib) % 65536);
      CMD_IN:  return sw;
      CMD_OUT: return a;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_step(input logic exp_ready);
    logic [15:0] b;
    logic acc, pop;
    b   = ImSel ? IMMG : RD2;
    acc = in_valid && exp_ready;
    pop = m_valid && out_ready;
    if (Reset) begin
      m_valid = 0; m_wdata = 0; m_bro = 0; m_rd = 0; m_wen = 0; m_br = 0;
      m_led = 0; mul_cnt = 0;
      return;
    end
    if (acc && EXE_CMD == CMD_OUT) m_led = RD1;
    if (Flush) begin
      m_valid = 0; mul_cnt = 0;
    end else if (mul_cnt == 1) begin
      if (!m_valid || out_ready) begin
        m_valid = 1; m_wdata = q_wdata; m_bro = q_bro; m_rd = q_rd;
        m_wen = q_wen; m_br = q_br; mul_cnt = 0;
      end
    end else if (mul_cnt > 1) begin
      mul_cnt--;
      if (pop) m_valid = 0;
    end else if (acc) begin
      if (EXE_CMD == CMD_MUL) begin
        mul_cnt = W + 1;
        q_wdata = ref_res(CMD_MUL, RD1, b, SW); q_bro = PC + IMMG;
        q_rd = Instruction[2:0]; q_wen = Reg_W_EN_IN; q_br = BranchTK_IN;
        if (pop) m_valid = 0;
      end else begin
        m_valid = 1; m_wdata = ref_res(int'(EXE_CMD), RD1, b, SW); m_bro = PC + IMMG;
        m_rd = Instruction[2:0]; m_wen = Reg_W_EN_IN; m_br = BranchTK_IN;
      end
    end else if (pop) begin
      m_valid = 0;
    end
  endtask

  // inputs are already driven after a negedge; compare again at the next negedge
  task automatic tick();
    logic exp_ready;
    #1;
    exp_ready = (mul_cnt == 0) && (!m_valid || out_ready) && !Flush;
    if (!Reset) chk("in_ready", in_ready, exp_ready);
    model_step(exp_ready);
    @(negedge clk);
    chk("out_valid", out_valid, m_valid);
    chk("LED", LED, m_led);
    if (m_valid) begin
      chk("Wdata", Wdata, m_wdata);
      chk("Broffset", Broffset, m_bro);
      chk("Rd", Rd, m_rd);
      chk("Reg_W_EN", Reg_W_EN, m_wen);
      chk("BranchTK", BranchTK, m_br);
    end else begin
      chk("Reg_W_EN_idle", Reg_W_EN, 0);
      chk("BranchTK_idle", BranchTK, 0);
    end
  endtask

  task automatic drive(input exe_cmd_t cmd, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] imm, input logic isel);
    in_valid = 1; EXE_CMD = cmd; RD1 = a; RD2 = b; IMMG = imm; ImSel = isel;
  endtask

  initial begin
    int n;
    Reset = 1; in_valid = 0; ImSel = 0; EXE_CMD = 0; Reg_W_EN_IN = 1; BranchTK_IN = 1;
    RD1 = 0; RD2 = 0; IMMG = 0; PC = 0; Instruction = 16'h0005; SW = 0; Flush = 0;
    out_ready = 1;
    @(negedge clk);
    tick(); tick();
    Reset = 0;
    #1;
    chk("rst_out_valid", out_valid, 0); chk("rst_Wdata", Wdata, 0);
    chk("rst_Broffset", Broffset, 0);   chk("rst_Rd", Rd, 0);
    chk("rst_LED", LED, 0);             chk("rst_in_ready", in_ready, 1);

    // ADD wrap into sign bit
    drive(CMD_ADD, 16'h7FFF, 16'h0000, 16'h0001, 1'b1);
    tick();
    chk("add_Wdata", Wdata, 16'h8000); chk("add_valid", out_valid, 1);

    // SUB wrap and branch-target wrap
    drive(CMD_SUB, 16'h0000, 16'h0001, 16'h0003, 1'b0); PC = 16'hFFFE; SW = 16'h1234;
    tick();
    chk("sub_Wdata", Wdata, 16'hFFFF); chk("sub_Broffset", Broffset, 16'h0001);

    // MUL latency
    drive(CMD_MUL, 16'h0123, 16'h0010, 16'h0000, 1'b0);
    tick();
    in_valid = 0; n = 0;
    while (!in_ready && n < 40) begin n++; tick(); end
    chk("mul_busy_cycles", n, 17);
    chk("mul_Wdata", Wdata, 16'h1230); chk("mul_valid", out_valid, 1);

    // stall with the slot full
    tick();
    out_ready = 0;
    drive(CMD_ADD, 16'h0001, 16'h0000, 16'h0002, 1'b1);
    tick();
    drive(CMD_ADD, 16'h000A, 16'h0000, 16'h0014, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_in_ready", in_ready, 0); chk("stall_Wdata", Wdata, 16'h0003);
    end
    out_ready = 1;
    tick();
    chk("stall_second", Wdata, 16'h001E);

    // LED output and switch input
    drive(CMD_OUT, 16'hA5A5, 16'h0000, 16'h0000, 1'b0);
    tick();
    drive(CMD_IN, 16'h0000, 16'h0000, 16'h0000, 1'b0); SW = 16'h003C;
    tick();
    chk("led_A5A5", LED, 16'hA5A5); chk("in_Wdata", Wdata, 16'h003C);

    // Flush mid-multiply
    drive(CMD_MUL, 16'h0005, 16'h0007, 16'h0000, 1'b0);
    tick();
    in_valid = 0;
    for (int i = 0; i < 3; i++) tick();
    Flush = 1; tick(); Flush = 0;
    chk("flush_valid", out_valid, 0); chk("flush_LED", LED, 16'hA5A5);
    for (int i = 0; i < 20; i++) tick();
    chk("flush_valid_late", out_valid, 0); chk("flush_in_ready", in_ready, 1);

    // Reset mid-multiply
    drive(CMD_MUL, 16'h0033, 16'h0011, 16'h0000, 1'b0);
    tick();
    in_valid = 0;
    for (int i = 0; i < 4; i++) tick();
    Reset = 1; tick(); Reset = 0;
    #1;
    chk("rst2_out_valid", out_valid, 0); chk("rst2_Wdata", Wdata, 0);
    chk("rst2_LED", LED, 0);             chk("rst2_in_ready", in_ready, 1);
    chk("rst2_Reg_W_EN", Reg_W_EN, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid    = ($urandom_range(2, 0) != 0);
      EXE_CMD     = 4'($urandom_range(11, 0));
      ImSel       = 1'($urandom);
      Reg_W_EN_IN = 1'($urandom);
      BranchTK_IN = 1'($urandom);
      RD1 = 16'($urandom); RD2 = 16'($urandom); IMMG = 16'($urandom);
      PC  = 16'($urandom); Instruction = 16'($urandom); SW = 16'($urandom);
      out_ready = ($urandom_range(3, 0) != 0);
      Flush     = ($urandom_range(29, 0) == 0);
      Reset     = ($urandom_range(499, 0) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
